// File: rtl/uart_report_tx.sv
// uart_report_tx: formats a time or DHT snapshot as an ASCII line and streams it to the UART TX core.
// Revision: 1.0
`default_nettype none

module uart_report_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic       report_req,
    input  logic       report_sel,
    input  logic [4:0] hour,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    input  logic [7:0] temp,
    input  logic [7:0] humid,
    input  logic       tx_busy,
    input  logic       tx_done,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       msg_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_T     = 8'h54;
    localparam logic [7:0] ASCII_H     = 8'h48;
    localparam logic [7:0] ASCII_EQ    = 8'h3D;
    localparam logic [7:0] ASCII_COMMA = 8'h2C;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [3:0] LAST_TIME   = 4'd9;
    localparam logic [3:0] LAST_DHT    = 4'd10;

    state_t     state, state_n;
    logic [3:0] idx, idx_n;
    logic       sel_q, sel_n;
    logic [4:0] hour_q, hour_n;
    logic [5:0] min_q, min_n;
    logic [5:0] sec_q, sec_n;
    logic [6:0] temp_q, temp_n;
    logic [6:0] humid_q, humid_n;
    logic       pending, pending_n;
    logic       pend_sel, pend_sel_n;
    logic       tx_start_n;
    logic [7:0] tx_data_n;
    logic       busy_n;
    logic       msg_done_n;
    logic [7:0] cur_byte;
    logic [3:0] last_idx;

    function automatic logic [6:0] sat99(input logic [7:0] v);
        return (v > 8'd99) ? 7'd99 : v[6:0];
    endfunction

    function automatic logic [7:0] dec_tens(input logic [6:0] v);
        logic [6:0] t;
        t = v / 7'd10;
        return ASCII_ZERO + {1'b0, t};
    endfunction

    function automatic logic [7:0] dec_ones(input logic [6:0] v);
        logic [6:0] o;
        o = v % 7'd10;
        return ASCII_ZERO + {1'b0, o};
    endfunction

    assign last_idx = sel_q ? LAST_DHT : LAST_TIME;

    // Byte selected from the frozen snapshot; only idx advances during a line.
    always_comb begin
        cur_byte = 8'h00;
        if (!sel_q) begin
            case (idx)
                4'd0:    cur_byte = dec_tens({2'b00, hour_q});
                4'd1:    cur_byte = dec_ones({2'b00, hour_q});
                4'd2:    cur_byte = ASCII_COLON;
                4'd3:    cur_byte = dec_tens({1'b0, min_q});
                4'd4:    cur_byte = dec_ones({1'b0, min_q});
                4'd5:    cur_byte = ASCII_COLON;
                4'd6:    cur_byte = dec_tens({1'b0, sec_q});
                4'd7:    cur_byte = dec_ones({1'b0, sec_q});
                4'd8:    cur_byte = ASCII_CR;
                4'd9:    cur_byte = ASCII_LF;
                default: cur_byte = 8'h00;
            endcase
        end else begin
            case (idx)
                4'd0:    cur_byte = ASCII_T;
                4'd1:    cur_byte = ASCII_EQ;
                4'd2:    cur_byte = dec_tens(temp_q);
                4'd3:    cur_byte = dec_ones(temp_q);
                4'd4:    cur_byte = ASCII_COMMA;
                4'd5:    cur_byte = ASCII_H;
                4'd6:    cur_byte = ASCII_EQ;
                4'd7:    cur_byte = dec_tens(humid_q);
                4'd8:    cur_byte = dec_ones(humid_q);
                4'd9:    cur_byte = ASCII_CR;
                4'd10:   cur_byte = ASCII_LF;
                default: cur_byte = 8'h00;
            endcase
        end
    end

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        sel_n      = sel_q;
        hour_n     = hour_q;
        min_n      = min_q;
        sec_n      = sec_q;
        temp_n     = temp_q;
        humid_n    = humid_q;
        pending_n  = pending;
        pend_sel_n = pend_sel;
        tx_start_n = 1'b0;
        tx_data_n  = tx_data;
        busy_n     = busy;
        msg_done_n = 1'b0;

        // A single request can queue behind the active line; extras are dropped.
        if (report_req && busy && !pending) begin
            pending_n  = 1'b1;
            pend_sel_n = report_sel;
        end

        case (state)
            IDLE: begin
                if (pending || report_req) begin
                    state_n   = SEND;
                    idx_n     = 4'd0;
                    busy_n    = 1'b1;
                    sel_n     = pending ? pend_sel : report_sel;
                    hour_n    = hour;
                    min_n     = min;
                    sec_n     = sec;
                    temp_n    = sat99(temp);
                    humid_n   = sat99(humid);
                    pending_n = 1'b0;
                end
            end
            SEND: begin
                if (!tx_busy) begin
                    tx_start_n = 1'b1;
                    tx_data_n  = cur_byte;
                    state_n    = WAIT;
                end
            end
            WAIT: begin
                if (tx_done) begin
                    if (idx == last_idx) begin
                        state_n    = IDLE;
                        msg_done_n = 1'b1;
                        busy_n     = 1'b0;
                    end else begin
                        idx_n   = idx + 4'd1;
                        state_n = SEND;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            idx      <= 4'd0;
            sel_q    <= 1'b0;
            hour_q   <= 5'd0;
            min_q    <= 6'd0;
            sec_q    <= 6'd0;
            temp_q   <= 7'd0;
            humid_q  <= 7'd0;
            pending  <= 1'b0;
            pend_sel <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            busy     <= 1'b0;
            msg_done <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            sel_q    <= sel_n;
            hour_q   <= hour_n;
            min_q    <= min_n;
            sec_q    <= sec_n;
            temp_q   <= temp_n;
            humid_q  <= humid_n;
            pending  <= pending_n;
            pend_sel <= pend_sel_n;
            tx_start <= tx_start_n;
            tx_data  <= tx_data_n;
            busy     <= busy_n;
            msg_done <= msg_done_n;
        end
    end

endmodule

`default_nettype wire
